// File: rtl/mem_lsq.sv
// In-order load/store queue: issues dmem requests oldest-first, formats load data, retires in enqueue order.
// Optional MEM_LSQ_MISALIGN_EN: misaligned H/W accesses complete without a request and retire with o_wb_err.
module mem_lsq #(
   parameter int DEPTH = 4,
   parameter int AW    = 32
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_vld,
   output logic          o_rdy,
   input  logic          i_ren,
   input  logic          i_wen,
   input  logic [2:0]    i_opsel,
   input  logic [AW-1:0] i_addr,
   input  logic [31:0]   i_wdata,
   input  logic [31:0]   i_res,
   input  logic [4:0]    i_rd_waddr,
   input  logic          i_rd_wen,
   output logic          o_req_vld,
   input  logic          i_req_rdy,
   output logic [AW-1:0] o_req_addr,
   output logic          o_req_wen,
   output logic [3:0]    o_req_mask,
   output logic [31:0]   o_req_wdata,
   input  logic          i_rsp_vld,
   input  logic [31:0]   i_rsp_rdata,
   output logic          o_wb_vld,
   output logic [31:0]   o_wb_data,
   output logic [4:0]    o_rd_waddr,
   output logic          o_rd_wen,
   output logic          o_wb_err,
   output logic          o_busy
);

   localparam int PW = $clog2(DEPTH);

   logic [DEPTH-1:0] valid_q, mem_q, load_q, issued_q, done_q, err_q, rdw_q;
   logic [2:0]       opsel_q [DEPTH];
   logic [1:0]       off_q   [DEPTH];
   logic [AW-3:0]    waddr_q [DEPTH];
   logic [31:0]      wdata_q [DEPTH];
   logic [31:0]      data_q  [DEPTH];
   logic [4:0]       rd_q    [DEPTH];

   logic [PW-1:0] head, iss, tail;
   logic [PW:0]   count;

   logic          enq, in_mem, in_err;
   logic [1:0]    in_off;
   logic          iss_live, iss_skip, iss_go, req_fire;
   logic          rsp_hit, rsp_take, rsp_at_head, retire;
   logic [PW-1:0] rsp_idx, scan_idx;
   logic [31:0]   rsp_data, ret_data;

   function automatic logic [31:0] fmt_load(input logic [31:0] rdata,
                                            input logic [2:0]  op,
                                            input logic [1:0]  off);
      logic [31:0] s;
      s = rdata >> {off, 3'b000};
      case (op)
         3'b000:  return {{24{s[7]}}, s[7:0]};
         3'b001:  return {{16{s[15]}}, s[15:0]};
         3'b100:  return {24'h0, s[7:0]};
         3'b101:  return {16'h0, s[15:0]};
         default: return s;
      endcase
   endfunction

   assign o_rdy  = (count != (PW+1)'(DEPTH));
   assign o_busy = (count != '0);
   assign enq    = i_vld && o_rdy;
   assign in_mem = i_ren || i_wen;

   // Offset bits below the access size are dropped; in misalign mode they flag an error instead.
   always_comb begin
      in_off = i_addr[1:0];
      in_err = 1'b0;
      case (i_opsel[1:0])
         2'b00: in_off = i_addr[1:0];
         2'b01: begin
            in_off = {i_addr[1], 1'b0};
`ifdef MEM_LSQ_MISALIGN_EN
            in_err = in_mem && i_addr[0];
`else
            in_err = 1'b0;
`endif
         end
         default: begin
            in_off = 2'b00;
`ifdef MEM_LSQ_MISALIGN_EN
            in_err = in_mem && (i_addr[1:0] != 2'b00);
`else
            in_err = 1'b0;
`endif
         end
      endcase
   end

   // Non-memory and error entries still pass through the issue pointer, one per cycle.
   assign iss_live  = valid_q[iss] && !issued_q[iss];
   assign iss_skip  = iss_live && (!mem_q[iss] || err_q[iss]);
   assign o_req_vld = iss_live && mem_q[iss] && !err_q[iss];
   assign req_fire  = o_req_vld && i_req_rdy;
   assign iss_go    = iss_skip || req_fire;

   assign o_req_addr = {waddr_q[iss], 2'b00};
   assign o_req_wen  = !load_q[iss];

   always_comb begin
      o_req_mask  = 4'b1111;
      o_req_wdata = wdata_q[iss];
      case (opsel_q[iss][1:0])
         2'b00: begin
            o_req_mask  = 4'b0001 << off_q[iss];
            o_req_wdata = {4{wdata_q[iss][7:0]}};
         end
         2'b01: begin
            o_req_mask  = 4'b0011 << off_q[iss];
            o_req_wdata = {2{wdata_q[iss][15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      rsp_hit  = 1'b0;
      rsp_idx  = head;
      scan_idx = head;
      for (int k = 0; k < DEPTH; k++) begin
         scan_idx = PW'(head + PW'(k));
         if (!rsp_hit && valid_q[scan_idx] && load_q[scan_idx] &&
             issued_q[scan_idx] && !done_q[scan_idx]) begin
            rsp_hit = 1'b1;
            rsp_idx = scan_idx;
         end
      end
   end

   assign rsp_take    = i_rsp_vld && rsp_hit;
   assign rsp_data    = fmt_load(i_rsp_rdata, opsel_q[rsp_idx], off_q[rsp_idx]);
   assign rsp_at_head = rsp_take && (rsp_idx == head);
   assign retire      = valid_q[head] && (done_q[head] || rsp_at_head);
   assign ret_data    = rsp_at_head ? rsp_data : data_q[head];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         head       <= '0;
         iss        <= '0;
         tail       <= '0;
         count      <= '0;
         valid_q    <= '0;
         o_wb_vld   <= 1'b0;
         o_wb_data  <= '0;
         o_rd_waddr <= '0;
         o_rd_wen   <= 1'b0;
         o_wb_err   <= 1'b0;
      end else begin
         if (enq) begin
            valid_q[tail]  <= 1'b1;
            mem_q[tail]    <= in_mem;
            load_q[tail]   <= i_ren;
            issued_q[tail] <= 1'b0;
            done_q[tail]   <= !in_mem || in_err;
            err_q[tail]    <= in_err;
            rdw_q[tail]    <= i_rd_wen;
            opsel_q[tail]  <= i_opsel;
            off_q[tail]    <= in_off;
            waddr_q[tail]  <= i_addr[AW-1:2];
            wdata_q[tail]  <= i_wdata;
            data_q[tail]   <= i_res;
            rd_q[tail]     <= i_rd_waddr;
            tail           <= tail + 1'b1;
         end
         if (iss_go) begin
            issued_q[iss] <= 1'b1;
            if (req_fire && !load_q[iss]) done_q[iss] <= 1'b1;
            iss <= iss + 1'b1;
         end
         if (rsp_take) begin
            done_q[rsp_idx] <= 1'b1;
            data_q[rsp_idx] <= rsp_data;
         end
         if (retire) begin
            valid_q[head] <= 1'b0;
            head          <= head + 1'b1;
            o_wb_data     <= ret_data;
            o_rd_waddr    <= rd_q[head];
            o_rd_wen      <= rdw_q[head] && !err_q[head];
            o_wb_err      <= err_q[head];
         end
         o_wb_vld <= retire;
         case ({enq, retire})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule
